btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 86 ++++++++
 rtl/btn_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg: shared game constants, debounce FSM encoding and channel output bundle
package btn_conditioner_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_CYCLES_DEF = 25000000;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HELD = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;
  typedef struct packed {
    logic pulse;
    logic level;
    logic busy;
  } ch_out_t;
  function automatic int cnt_w(input int d, input int r);
    int m;
    m = (d > r) ? d : r;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel (2-flop synchronizer, debounce/repeat FSM, counter)
// Ports: ClkPort clock, Reset async active-high, i_btn raw button,
//        o_ch registered {pulse, level, busy} for this channel
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic    ClkPort,
  input  logic    Reset,
  input  logic    i_btn,
  output ch_out_t o_ch
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [1:0] r_sync;
  logic [2:0] r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_pulse, r_level, r_busy;
  logic w_in, w_db_done, w_rp_done;
  assign w_in = r_sync[1];
  assign w_db_done = r_cnt == DB_LAST;
  assign w_rp_done = r_cnt == RP_LAST;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt + 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_cnt = '0;
        w_next = w_in ? ST_PRESS_WAIT : ST_IDLE;
      end
      ST_PRESS_WAIT: begin
        if (!w_in || w_db_done) w_cnt = '0;
        if (!w_in) w_next = ST_IDLE;
        else if (w_db_done) w_next = ST_PULSE;
      end
      ST_PULSE: begin
        w_cnt = '0;
        w_next = ST_HELD;
      end
      ST_HELD: begin
        if (!w_in) begin
          w_cnt = '0;
          w_next = ST_RELEASE_WAIT;
        end else if (w_rp_done) begin
          // without auto-repeat the counter parks at its terminal value
          w_cnt = REPEAT_EN ? '0 : r_cnt;
          w_next = REPEAT_EN ? ST_PULSE : ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_in || w_db_done) w_cnt = '0;
        if (w_in) w_next = ST_HELD;
        else if (w_db_done) w_next = ST_IDLE;
      end
      default: begin
        w_cnt = '0;
        w_next = ST_IDLE;
      end
    endcase
  end
  // outputs are flops loaded from the next-state decode so they track r_state exactly
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_sync <= '0;
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_pulse <= w_next == ST_PULSE;
      r_level <= w_next inside {ST_PULSE, ST_HELD, ST_RELEASE_WAIT};
      r_busy <= w_next != ST_IDLE;
    end
  end
  assign o_ch.pulse = r_pulse;
  assign o_ch.level = r_level;
  assign o_ch.busy = r_busy;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: four independent debounced push-button channels for the game controller
// Ports: ClkPort clock, Reset async active-high, BtnU/D/L/R raw buttons,
//        up_p/down_p/left_p/right_p one-cycle press pulses, up_l/down_l/left_l/right_l
//        debounced levels, busy high while any channel is not idle
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnL,
  input  logic BtnR,
  output logic up_p,
  output logic down_p,
  output logic left_p,
  output logic right_p,
  output logic up_l,
  output logic down_l,
  output logic left_l,
  output logic right_l,
  output logic busy
);
  logic [3:0] w_btn;
  ch_out_t w_ch [4];
  assign w_btn = {BtnU, BtnD, BtnL, BtnR};
  for (genvar i = 0; i < 4; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_EN)
    ) u_ch (
      .ClkPort(ClkPort),
      .Reset(Reset),
      .i_btn(w_btn[i]),
      .o_ch(w_ch[i])
    );
  end
  assign {up_p, down_p, left_p, right_p} = {w_ch[3].pulse, w_ch[2].pulse, w_ch[1].pulse, w_ch[0].pulse};
  assign {up_l, down_l, left_l, right_l} = {w_ch[3].level, w_ch[2].level, w_ch[1].level, w_ch[0].level};
  assign busy = w_ch[0].busy | w_ch[1].busy | w_ch[2].busy | w_ch[3].busy;
endmodule
